// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM for the multicycle MIPS datapath. It steps one instruction
//   through fetch, decode, execute, memory and writeback. It drives every
//   datapath enable and mux select, plus the 2-bit ALU_op for ALU_Control.
//   Memory accesses stall on mem_ready.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   opcode[5:0]  IR[31:26], stable outside FETCH
//   mem_ready    memory completes the current access this cycle
//   PCWrite, PCWriteCond, PCSource[1:0]   PC update controls
//   IorD, MemRead, MemWrite, IRWrite      memory / IR controls
//   MemtoReg, RegDst, RegWrite            register file controls
//   ALUSrcA, ALUSrcB[1:0], ALU_op[1:0]    ALU operand / operation controls
//   instr_done   pulse on the final cycle of each instruction
//   illegal_op   pulse on decode of an unsupported opcode
//
// Build option
//   MULTICYCLE_ADDI_EN  when defined, opcode 001000 (addi) runs through
//                       ADDIEX/ADDIWB; otherwise it decodes as illegal.
//
// state  | meaning
// RST    | post-reset hold, all outputs 0
// FETCH  | read instruction at PC, PC+4, wait on mem_ready
// DECODE | register read, branch target in ALUOut
// MEMADR | lw/sw effective address
// MEMRD  | lw data read, wait on mem_ready
// MEMWB  | lw write-back from MDR
// MEMWR  | sw data write, wait on mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | R-type write-back to rd
// BRANCH | beq compare and conditional PC load
// JUMP   | j target PC load
// ADDIEX | addi ALU operation (build option)
// ADDIWB | addi write-back to rt (build option)

module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALU_op,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10
`ifdef MULTICYCLE_ADDI_EN
    ,
    ST_ADDIEX = 4'd11,
    ST_ADDIWB = 4'd12
`endif
  } state_t;

  state_t state_q, state_d;
  // Cleared by reset, set on the first edge after release; RST only advances
  // once it is set, so RST covers one full cycle after reset deasserts.
  logic   rst_dly_q, rst_dly_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RST;
      rst_dly_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_dly_q <= rst_dly_d;
    end
  end

  always_comb begin
    rst_dly_d = 1'b1;
    state_d   = ST_RST;
    case (state_q)
      ST_RST:    state_d = rst_dly_q ? ST_FETCH : ST_RST;
      ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      state_d = ST_ADDIEX;
`endif
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  state_d = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:  state_d = ST_FETCH;
      ST_MEMWR:  state_d = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ALUWB:  state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
`ifdef MULTICYCLE_ADDI_EN
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_ADDIWB: state_d = ST_FETCH;
`endif
      default:   state_d = ST_RST;
    endcase
  end

  // Moore decode; only the FETCH PC/IR loads and the MEMWR done pulse look at
  // mem_ready. Because RST decodes to all zeros, asserting rst kills any
  // write-back in flight without waiting for a clock edge.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALU_op      = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      ST_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: illegal_op = 1'b0;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:                              illegal_op = 1'b0;
`endif
          default:                              illegal_op = 1'b1;
        endcase
      end
      ST_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ST_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      ST_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      ST_EXEC: begin
        ALUSrcA = 1'b1;
        ALU_op  = 2'b10;
      end
      ST_ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALU_op      = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      ST_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
`ifdef MULTICYCLE_ADDI_EN
      ST_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ST_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk, rst, mem_ready;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] PCSource, ALUSrcB, ALU_op;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_op(ALU_op),
    .instr_done(instr_done), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle, MSB first.
  logic [17:0] act;
  assign act = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
                IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
                ALU_op, instr_done, illegal_op};

  localparam logic [17:0] P_PCW  = 18'h20000, P_PCWC = 18'h10000;
  localparam logic [17:0] P_PCS1 = 18'h04000, P_PCS2 = 18'h08000;
  localparam logic [17:0] P_IORD = 18'h02000, P_MRD  = 18'h01000;
  localparam logic [17:0] P_MWR  = 18'h00800, P_IRW  = 18'h00400;
  localparam logic [17:0] P_M2R  = 18'h00200, P_RDST = 18'h00100;
  localparam logic [17:0] P_RW   = 18'h00080, P_ASA  = 18'h00040;
  localparam logic [17:0] P_ASB1 = 18'h00010, P_ASB2 = 18'h00020;
  localparam logic [17:0] P_ASB3 = 18'h00030, P_AOP1 = 18'h00004;
  localparam logic [17:0] P_AOP2 = 18'h00008, P_DONE = 18'h00002;
  localparam logic [17:0] P_ILL  = 18'h00001;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [17:0] a, input logic [17:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // Reference model: each instruction is a microprogram of output words.
  // A step either always advances or waits on mem_ready; mrm holds the bits
  // that follow mem_ready during that step.
  typedef struct {
    logic [17:0] base;
    logic [17:0] mrm;
    bit          wt;
    bit          is_fetch;
  } step_t;

  step_t prog[$];
  int    pi = 0;
  int    post_rst = 2;
  bit    can_chg = 1'b1;

  function automatic step_t mk(logic [17:0] b, logic [17:0] m, bit w, bit f);
    step_t s;
    s.base = b; s.mrm = m; s.wt = w; s.is_fetch = f;
    return s;
  endfunction

  function automatic step_t fetch_step();
    return mk(P_MRD | P_ASB1, P_PCW | P_IRW, 1'b1, 1'b1);
  endfunction

  task automatic load_prog(input logic [5:0] op);
    step_t dec;
    dec = mk(P_ASB3, 18'd0, 1'b0, 1'b0);
    prog.delete();
    case (op)
      6'b100011: begin
        prog.push_back(dec);
        prog.push_back(mk(P_ASA | P_ASB2, 18'd0, 1'b0, 1'b0));
        prog.push_back(mk(P_MRD | P_IORD, 18'd0, 1'b1, 1'b0));
        prog.push_back(mk(P_RW | P_M2R | P_DONE, 18'd0, 1'b0, 1'b0));
      end
      6'b101011: begin
        prog.push_back(dec);
        prog.push_back(mk(P_ASA | P_ASB2, 18'd0, 1'b0, 1'b0));
        prog.push_back(mk(P_MWR | P_IORD, P_DONE, 1'b1, 1'b0));
      end
      6'b000000: begin
        prog.push_back(dec);
        prog.push_back(mk(P_ASA | P_AOP2, 18'd0, 1'b0, 1'b0));
        prog.push_back(mk(P_RW | P_RDST | P_DONE, 18'd0, 1'b0, 1'b0));
      end
      6'b000100: begin
        prog.push_back(dec);
        prog.push_back(mk(P_ASA | P_AOP1 | P_PCWC | P_PCS1 | P_DONE, 18'd0, 1'b0, 1'b0));
      end
      6'b000010: begin
        prog.push_back(dec);
        prog.push_back(mk(P_PCW | P_PCS2 | P_DONE, 18'd0, 1'b0, 1'b0));
      end
`ifdef MULTICYCLE_ADDI_EN
      6'b001000: begin
        prog.push_back(dec);
        prog.push_back(mk(P_ASA | P_ASB2, 18'd0, 1'b0, 1'b0));
        prog.push_back(mk(P_RW | P_DONE, 18'd0, 1'b0, 1'b0));
      end
`endif
      default: prog.push_back(mk(P_ASB3 | P_ILL, 18'd0, 1'b0, 1'b0));
    endcase
  endtask

  // Compare process: every negedge, outputs against the model.
  always @(negedge clk) begin : model
    step_t       s;
    logic [17:0] e;
    if (rst) begin
      chk("outs_in_reset", act, 18'd0);
      post_rst = 2;
      can_chg  = 1'b1;
    end else if (post_rst != 0) begin
      chk("outs_rst_state", act, 18'd0);
      post_rst--;
      can_chg = 1'b1;
      if (post_rst == 0) begin
        prog.delete();
        prog.push_back(fetch_step());
        pi = 0;
      end
    end else begin
      s = prog[pi];
      e = s.base | (mem_ready ? s.mrm : 18'd0);
      chk("outs", act, e);
      if (!s.wt || mem_ready) begin
        if (s.is_fetch) begin
          load_prog(opcode);
          pi = 0;
        end else begin
          pi++;
          if (pi >= prog.size()) begin
            prog.delete();
            prog.push_back(fetch_step());
            pi = 0;
          end
        end
      end
      can_chg = prog[pi].is_fetch;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 6'b100011;
      1: return 6'b101011;
      2: return 6'b000000;
      3: return 6'b000100;
      4: return 6'b000010;
      5: return 6'b001000;
      6: return 6'b111111;
      default: return 6'($urandom);
    endcase
  endfunction

  int n_mw;

  initial begin
    rst = 1'b1; mem_ready = 1'b0; opcode = 6'b000000;
    #1;
    chk("reset_outs", act, 18'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; opcode = 6'b100011; mem_ready = 1'b1;
    chk("rst_cycle1", act, 18'd0);
    tick(); chk("rst_cycle2", act, 18'd0);
    // lw, no wait states
    tick(); chk("lw_fetch", {MemRead, IRWrite, PCWrite, ALUSrcB}, 18'b11101);
    tick(); chk("lw_decode", {16'd0, ALUSrcB}, 18'd3);
    tick(); chk("lw_memadr", {ALUSrcA, ALUSrcB}, 18'b110);
    tick(); chk("lw_memrd", {MemRead, IorD, RegWrite}, 18'b110);
    tick(); chk("lw_memwb", {RegWrite, MemtoReg, instr_done}, 18'b111);
    // async reset in the middle of MEMWB
    #2 rst = 1'b1;
    #1 chk("async_rst_regwrite", {17'd0, RegWrite}, 18'd0);
    @(posedge clk); #1;
    rst = 1'b0; opcode = 6'b101011; mem_ready = 1'b1;
    chk("rst2_cycle1", act, 18'd0);
    tick(); chk("rst2_cycle2", act, 18'd0);
    // sw with three wait states in MEMWR
    tick(); chk("sw_fetch", {17'd0, MemRead}, 18'd1);
    tick();
    tick();
    n_mw = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_ready = (i == 3);
      #1;
      if (MemWrite && IorD) n_mw++;
      chk("sw_done", {17'd0, instr_done}, {17'd0, (i == 3)});
    end
    chk("sw_memwrite_cycles", 18'(n_mw), 18'd4);
    // FETCH stalled for two cycles, then R-type
    tick();
    mem_ready = 1'b0; opcode = 6'b000000; #1;
    chk("sw_next_fetch", {MemRead, IorD}, 18'b10);
    chk("fetch_stall1", {IRWrite, PCWrite}, 18'b00);
    tick(); chk("fetch_stall2", {IRWrite, PCWrite}, 18'b00);
    tick(); mem_ready = 1'b1; #1;
    chk("fetch_go", {IRWrite, PCWrite}, 18'b11);
    tick();
    tick(); chk("rtype_exec", {ALUSrcA, ALUSrcB, ALU_op}, 18'b10010);
    tick(); chk("rtype_aluwb", {RegWrite, RegDst, MemtoReg, instr_done}, 18'b1101);
    // beq
    tick(); opcode = 6'b000100;
    tick();
    tick(); chk("beq_branch", {PCWriteCond, PCSource, ALU_op, instr_done}, 18'b101011);
    // illegal opcode
    tick(); opcode = 6'b111111;
    tick(); chk("illegal_dec", {illegal_op, RegWrite, MemWrite, PCWrite, PCWriteCond}, 18'b10000);
    tick(); chk("illegal_refetch", {MemRead, illegal_op}, 18'b10);
    opcode = 6'b001000;
    tick();
`ifdef MULTICYCLE_ADDI_EN
    chk("addi_dec", {17'd0, illegal_op}, 18'd0);
    tick(); chk("addi_ex", {ALUSrcA, ALUSrcB}, 18'b110);
`else
    chk("addi_dec_illegal", {17'd0, illegal_op}, 18'd1);
    tick(); chk("addi_refetch", {MemRead, RegWrite}, 18'b10);
`endif
    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst = (i == 1500);
      mem_ready = ($urandom_range(0, 3) != 0);
      if (can_chg) opcode = pick_op();
    end
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
